// File: rtl/io_map_pkg.sv
// io_map_pkg: IO register addresses, STATUS bit positions and read-select encoding.
package io_map_pkg;
  localparam logic [15:0] SWITCHES_LOC = 16'hCFFD;
  localparam logic [15:0] LEDS_LOC     = 16'hCFFE;
  localparam logic [15:0] STATUS_LOC   = 16'hCFFF;
  localparam logic [15:0] TIMER_LOC    = 16'hD000;
  localparam int TMR_WRAP_BIT = 0;
  localparam int SW_CHG_BIT   = 1;
  localparam int IEN_TMR_BIT  = 8;
  localparam int IEN_SW_BIT   = 9;
  typedef enum logic [2:0] {SEL_RAM, SEL_SW, SEL_LED, SEL_STAT, SEL_TMR} sel_e;
  function automatic sel_e decode(input logic [15:0] addr);
    return addr == SWITCHES_LOC ? SEL_SW :
           addr == LEDS_LOC     ? SEL_LED :
           addr == STATUS_LOC   ? SEL_STAT :
           addr == TIMER_LOC    ? SEL_TMR : SEL_RAM;
  endfunction
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchronizer plus stability counter for board switches.
//   clk, reset (async active-low), raw: asynchronous input,
//   stable: accepted value, changed: one-cycle pulse when the accepted value changes.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [WIDTH-1:0] s1_q, s2_q, cand_q, stable_q;
  logic [CW-1:0] cnt_q;
  logic accept;
  // Accept on the edge the counter steps into DEBOUNCE_CYCLES-1, giving 2+DEBOUNCE_CYCLES total latency.
  assign accept  = s2_q == cand_q && cnt_q == CW'(DEBOUNCE_CYCLES - 2);
  assign changed = accept && cand_q != stable_q;
  assign stable  = stable_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (accept) stable_q <= cand_q;
    end
  end
endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped IO registers on CPU port A alongside EXRAM.
//   clk, reset (async active-low); address_a/data_a/wren_a: CPU bus; q_a: EXRAM read data;
//   switches: raw board switches; ram_wren_a: gated EXRAM write enable;
//   mem_rdata: read data to CPU; seg_value: display value; irq: level interrupt.
module io_bus_responder
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_a,
  input  logic [15:0] data_a,
  input  logic        wren_a,
  input  logic [15:0] q_a,
  input  logic [7:0]  switches,
  output logic        ram_wren_a,
  output logic [15:0] mem_rdata,
  output logic [15:0] seg_value,
  output logic        irq
);
  localparam int TW = $clog2(TICK_DIV);
  sel_e sel_d, sel_q;
  logic [15:0] io_rd_d, io_rd_q, seg_d, seg_q, timer_d, timer_q, status;
  logic [TW-1:0] presc_d, presc_q;
  logic [1:0] ien_d, ien_q, clr;
  logic sw_chg_d, sw_chg_q, tmr_wrap_d, tmr_wrap_q, irq_d, irq_q;
  logic wr_led, wr_stat, wr_tmr, rd_stat, tick, sw_changed;
  logic [7:0] sw_stable;
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(8)) u_deb (
    .clk(clk), .reset(reset), .raw(switches), .stable(sw_stable), .changed(sw_changed)
  );
  assign sel_d      = decode(address_a);
  assign ram_wren_a = wren_a & (sel_d == SEL_RAM);
  assign wr_led     = wren_a & (sel_d == SEL_LED);
  assign wr_stat    = wren_a & (sel_d == SEL_STAT);
  assign wr_tmr     = wren_a & (sel_d == SEL_TMR);
  // With no read strobe on the bus, any non-write cycle addressing STATUS counts as a read.
  assign rd_stat    = ~wren_a & (sel_d == SEL_STAT);
  assign tick       = presc_q == TW'(TICK_DIV - 1);
  always_comb begin
    status = '0;
    status[IEN_SW_BIT]   = ien_q[1];
    status[IEN_TMR_BIT]  = ien_q[0];
    status[SW_CHG_BIT]   = sw_chg_q;
    status[TMR_WRAP_BIT] = tmr_wrap_q;
    clr        = rd_stat ? 2'b11 : wr_stat ? data_a[1:0] : 2'b00;
    seg_d      = wr_led ? data_a : seg_q;
    ien_d      = wr_stat ? data_a[IEN_SW_BIT:IEN_TMR_BIT] : ien_q;
    timer_d    = wr_tmr ? data_a : tick ? timer_q + 16'd1 : timer_q;
    presc_d    = (wr_tmr | tick) ? '0 : presc_q + TW'(1);
    tmr_wrap_d = (tick & ~wr_tmr & timer_q == 16'hFFFF) | (tmr_wrap_q & ~clr[TMR_WRAP_BIT]);
    sw_chg_d   = sw_changed | (sw_chg_q & ~clr[SW_CHG_BIT]);
    irq_d      = (sw_chg_d & ien_d[1]) | (tmr_wrap_d & ien_d[0]);
    io_rd_d    = sel_d == SEL_SW   ? {8'h00, sw_stable} :
                 sel_d == SEL_LED  ? seg_q :
                 sel_d == SEL_STAT ? status :
                 sel_d == SEL_TMR  ? timer_q : 16'h0000;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= SEL_RAM;
      io_rd_q    <= '0;
      seg_q      <= '0;
      timer_q    <= '0;
      presc_q    <= '0;
      ien_q      <= '0;
      sw_chg_q   <= 1'b0;
      tmr_wrap_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      io_rd_q    <= io_rd_d;
      seg_q      <= seg_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      ien_q      <= ien_d;
      sw_chg_q   <= sw_chg_d;
      tmr_wrap_q <= tmr_wrap_d;
      irq_q      <= irq_d;
    end
  end
  assign mem_rdata = sel_q == SEL_RAM ? q_a : io_rd_q;
  assign seg_value = seg_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed self-checking bench for io_bus_responder.
module tb_io_bus_responder;
  logic clk = 1'b0, reset = 1'b0, wren_a = 1'b0, ram_wren_a, irq;
  logic [15:0] address_a = 16'h0010, data_a = 16'h0000, q_a = 16'hBEEF, mem_rdata, seg_value;
  logic [7:0] switches = 8'h00;
  int errors = 0, checks = 0;
  io_bus_responder #(.DEBOUNCE_CYCLES(4), .TICK_DIV(3)) dut (
    .clk(clk), .reset(reset), .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
    .q_a(q_a), .switches(switches), .ram_wren_a(ram_wren_a), .mem_rdata(mem_rdata),
    .seg_value(seg_value), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address_a = a;
    data_a = d;
    wren_a = 1'b1;
    cyc(1);
    wren_a = 1'b0;
    address_a = 16'h0010;
  endtask
  task automatic test_reset;
    #1;
    chk16("reset_rdata", mem_rdata, 16'hBEEF);
    chk16("reset_seg", seg_value, 16'h0000);
    chk1("reset_irq", irq, 1'b0);
    chk1("reset_wren", ram_wren_a, 1'b0);
    cyc(2);
    reset = 1'b1;
  endtask
  task automatic test_ram_pass;
    cyc(1);
    chk16("ram_rdata", mem_rdata, 16'hBEEF);
    wren_a = 1'b1;
    #1 chk1("ram_wren_0010", ram_wren_a, 1'b1);
    address_a = 16'hCFFC;
    #1 chk1("ram_wren_cffc", ram_wren_a, 1'b1);
    address_a = 16'hD001;
    #1 chk1("ram_wren_d001", ram_wren_a, 1'b1);
    address_a = 16'hCFFD;
    #1 chk1("ram_wren_cffd", ram_wren_a, 1'b0);
    address_a = 16'hD000;
    #1 chk1("ram_wren_d000", ram_wren_a, 1'b0);
    wren_a = 1'b0;
    address_a = 16'h0010;
    cyc(1);
  endtask
  task automatic test_leds;
    address_a = 16'hCFFE;
    data_a = 16'h1234;
    wren_a = 1'b1;
    #1 chk1("led_wren_gated", ram_wren_a, 1'b0);
    cyc(1);
    chk16("led_seg", seg_value, 16'h1234);
    wren_a = 1'b0;
    q_a = 16'h0000;
    cyc(1);
    chk16("led_read", mem_rdata, 16'h1234);
    address_a = 16'h0010;
    q_a = 16'hBEEF;
    cyc(1);
    chk16("led_back_to_ram", mem_rdata, 16'hBEEF);
  endtask
  task automatic test_debounce;
    address_a = 16'hCFFD;
    switches = 8'hA5;
    cyc(6);
    chk16("deb_before", mem_rdata, 16'h0000);
    cyc(1);
    chk16("deb_accept", mem_rdata, 16'h00A5);
    address_a = 16'hCFFF;
    cyc(1);
    chk16("deb_status", mem_rdata, 16'h0002);
    cyc(1);
    chk16("deb_status_cleared", mem_rdata, 16'h0000);
    address_a = 16'hCFFD;
    switches = 8'h00;
    cyc(2);
    switches = 8'hA5;
    cyc(10);
    chk16("glitch_value", mem_rdata, 16'h00A5);
    address_a = 16'hCFFF;
    cyc(1);
    chk16("glitch_status", mem_rdata, 16'h0000);
    address_a = 16'h0010;
  endtask
  task automatic test_irq;
    wr(16'hCFFF, 16'h0200);
    switches = 8'h3C;
    cyc(5);
    chk1("irq_before", irq, 1'b0);
    cyc(1);
    chk1("irq_set", irq, 1'b1);
    address_a = 16'hCFFF;
    cyc(1);
    chk16("irq_status_read", mem_rdata, 16'h0202);
    chk1("irq_cleared", irq, 1'b0);
    cyc(1);
    chk16("irq_status_after", mem_rdata, 16'h0200);
    address_a = 16'h0010;
    switches = 8'hC3;
    cyc(5);
    address_a = 16'hCFFF;
    cyc(1);
    chk16("same_cycle_read", mem_rdata, 16'h0200);
    chk1("same_cycle_set_wins", irq, 1'b1);
    cyc(1);
    chk16("same_cycle_next_read", mem_rdata, 16'h0202);
    chk1("same_cycle_irq_drop", irq, 1'b0);
    address_a = 16'h0010;
  endtask
  task automatic test_timer;
    wr(16'hCFFF, 16'h0100);
    wr(16'hD000, 16'hFFFE);
    address_a = 16'hD000;
    cyc(1);
    chk16("tmr_read_fffe", mem_rdata, 16'hFFFE);
    cyc(3);
    chk16("tmr_read_ffff", mem_rdata, 16'hFFFF);
    cyc(1);
    chk1("tmr_irq_before", irq, 1'b0);
    cyc(1);
    chk1("tmr_irq_wrap", irq, 1'b1);
    cyc(1);
    chk16("tmr_read_0000", mem_rdata, 16'h0000);
    wr(16'hCFFF, 16'h0101);
    chk1("tmr_w1c_irq", irq, 1'b0);
    address_a = 16'hCFFF;
    cyc(1);
    chk16("tmr_w1c_status", mem_rdata, 16'h0100);
    address_a = 16'h0010;
  endtask
  task automatic test_reset_mid;
    wr(16'hCFFF, 16'h0200);
    wr(16'hCFFE, 16'h1234);
    address_a = 16'hCFFD;
    switches = 8'hFF;
    cyc(6);
    chk16("rm_old_sw", mem_rdata, 16'h00C3);
    chk1("rm_irq_pre", irq, 1'b1);
    cyc(1);
    chk16("rm_new_sw", mem_rdata, 16'h00FF);
    chk16("rm_seg_pre", seg_value, 16'h1234);
    switches = 8'h11;
    q_a = 16'h0000;
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk16("rm_rdata", mem_rdata, 16'h0000);
    chk16("rm_seg", seg_value, 16'h0000);
    chk1("rm_irq", irq, 1'b0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk16("rm_sw_after", mem_rdata, 16'h0000);
    cyc(5);
    chk16("rm_sw_still0", mem_rdata, 16'h0000);
    cyc(1);
    chk16("rm_sw_redeb", mem_rdata, 16'h0011);
    chk16("rm_seg_after", seg_value, 16'h0000);
  endtask
  initial begin
    test_reset;
    test_ram_pass;
    test_leds;
    test_debounce;
    test_irq;
    test_timer;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder for CPU memory port A. It sits between the CPU bus (address_a/data_a/wren_a), the EXRAM port-A read data and the board I/O.
- Decodes the IO register window and owns the registers in it: switch input, 7-seg display, status, and a millisecond timer.
- Gates the RAM write enable for register addresses and returns read data aligned to EXRAM's one-cycle registered read latency.
- Also debounces the switches and raises a level interrupt.

Parameters:
- SWITCHES_LOC, 16'hCFFD, read-only debounced switches.
- LEDS_LOC, 16'hCFFE, R/W 16-bit 7-seg display value.
- STATUS_LOC, 16'hCFFF, status/interrupt-enable register.
- TIMER_LOC, 16'hD000, R/W 16-bit ms timer.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a switch value (>=2).
- TICK_DIV, 50000, clk cycles per timer increment (1 ms at 50 MHz; >=2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- address_a  in  16  CPU bus address
- data_a  in  16  CPU write data
- wren_a  in  1  CPU write strobe
- q_a  in  16  EXRAM port-A registered read data
- switches  in  8  raw asynchronous board switches
- ram_wren_a  out  1  write enable to EXRAM port A
- mem_rdata  out  16  read data returned to CPU
- seg_value  out  16  display value driving the four hexTo7Seg_3710 units
- irq  out  1  level interrupt to CPU

Behaviour:
- Reset (reset==0, async):
  - seg_value=0, status=0, timer=0, prescaler=0.
  - Debounced switches=0, sync flops=0, stability counter=0.
  - Read-select register=RAM, so mem_rdata=q_a and irq=0.
- Decode (combinational):
  - hit_reg = address_a is one of the four *_LOC addresses.
  - ram_wren_a = wren_a & ~hit_reg.
  - Any other address, including other addresses >=16'hCFFD, passes through to RAM unchanged.
- Read path, 1-cycle latency:
  - On every edge, register sel<=decode(address_a) and io_rd<=the register value addressed.
  - mem_rdata = (sel==RAM) ? q_a : io_rd, so IO reads match EXRAM timing.
  - SWITCHES reads {8'h00, debounced}.
  - STATUS reads {6'b0, ien[1:0], 6'b0, sw_chg, tmr_wrap}, with ien at bits 9:8 and sw_chg at bit 1.
- Writes take effect at the edge where wren_a=1:
  - LEDS: seg_value<=data_a.
  - SWITCHES: ignored.
  - STATUS: ien<=data_a[9:8]; data_a[1:0] is write-1-to-clear for sw_chg/tmr_wrap.
  - TIMER: timer<=data_a and prescaler<=0.
- Switch debouncer:
  - Two-flop synchronizer, then a counter. The counter resets whenever the synced value differs from the candidate (the candidate reloads).
  - When the counter reaches DEBOUNCE_CYCLES-1, the candidate is accepted into the debounced register.
  - Any accepted change in value sets sw_chg.
  - Input-to-accepted latency = 2 + DEBOUNCE_CYCLES cycles.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; at wrap, timer increments.
  - Timer 16'hFFFF->0 sets tmr_wrap.
  - A write to TIMER in the same cycle as a tick takes priority; no increment and no wrap flag.
- Sticky flags: cleared by a STATUS read (the read captures the pre-clear value in io_rd) or by W1C. If a set and a clear hit in the same cycle, set wins.
- irq = (sw_chg & ien[1]) | (tmr_wrap & ien[0]), registered from flag state (no combinational path from the bus).
- Reset mid-operation: all state clears immediately. The partially counted debounce is discarded.
- A CPU write and a display write never conflict: there is a single bus port.

Decomposition:
- Package io_map_pkg: the four *_LOC addresses, the STATUS bit indices (TMR_WRAP_BIT=0, SW_CHG_BIT=1, IEN_TMR_BIT=8, IEN_SW_BIT=9) and the read-select encoding (SEL_RAM, SEL_SW, SEL_LED, SEL_STAT, SEL_TMR).
- One sub-module, switch_debouncer (parameter DEBOUNCE_CYCLES, WIDTH=8; ports clk, reset, raw, stable, changed pulse).

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=3):
- Reset released, address_a=16'h0010, q_a=16'hBEEF → mem_rdata=16'hBEEF one cycle later; ram_wren_a follows wren_a.
- Write 16'h1234 to 16'hCFFE → ram_wren_a=0 that cycle; seg_value=16'h1234 next edge; a read of CFFE returns 16'h1234 one cycle after the address.
- switches=8'hA5 held → debounced switches=8'hA5 after 6 cycles; sw_chg=1. A 2-cycle glitch to 8'h00 leaves the value at 8'hA5.
- STATUS write 16'h0200, then switch change → irq=1. STATUS read returns 16'h0202 and sw_chg clears; irq drops the next cycle. With a change accepted in the same cycle as the read, sw_chg stays 1.
- Write TIMER=16'hFFFE, ien=16'h0100 → after 6 cycles timer=0, tmr_wrap=1, irq=1. Writing STATUS 16'h0101 clears the flag.
- Assert reset mid-debounce and with seg_value=16'h1234 → all outputs 0 asynchronously; after release, a read of CFFD returns 16'h0000 until the new switch value is re-debounced.
